// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: handshaked MEM-stage load/store unit for the RV32 pipeline.
// Formats stores onto byte lanes and extends loads. Detects illegal,
// misaligned and faulted (bus error or timeout) accesses, and stalls the
// pipeline while a data-memory transfer is in flight.
// Optional feature: define LSU_HALFWORD_EN to support LH, LHU and SH.
module lsu_mem_stage #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ValidM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        funct3M,
    input  logic [ADDR_W-1:0] ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic              FlushM,
    output logic              StallM,
    output logic [31:0]       ReadDataM,
    output logic              ExcM,
    output logic [3:0]        ExcCauseM,
    output logic              dmem_req,
    output logic [ADDR_W-1:0] dmem_A,
    output logic [31:0]       dmem_WD,
    output logic [3:0]        dmem_BE,
    output logic              dmem_WE,
    input  logic              dmem_ready,
    input  logic              dmem_err,
    input  logic [31:0]       dmem_RD
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LD_MISAL  = 4'd4;
    localparam logic [3:0] CAUSE_LD_FAULT  = 4'd5;
    localparam logic [3:0] CAUSE_ST_MISAL  = 4'd6;
    localparam logic [3:0] CAUSE_ST_FAULT  = 4'd7;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    localparam logic [7:0] CNT_MAX     = 8'hFF;

    logic [1:0]        state_q, state_d;
    logic              discard_q, discard_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic              is_load_q, is_load_d;

    logic              req_d, we_d, exc_d;
    logic [ADDR_W-1:0] a_d;
    logic [31:0]       wd_d, rd_d;
    logic [3:0]        be_d, cause_d;

    logic              accept, illegal, misaligned;
    logic [1:0]        off;
    logic [31:0]       st_wd;
    logic [3:0]        st_be;
    logic [31:0]       lane, ld_data;

    // Decode the op presented in MEM: legality, alignment and lane formatting.
    always_comb begin
        accept  = ValidM & (MemReadM | MemWriteM) & ~FlushM;
        off     = ALUResultM[1:0];
        illegal = 1'b0;
        if (MemReadM & MemWriteM) begin
            illegal = 1'b1;
        end else if (MemReadM) begin
            case (funct3M)
                3'b000, 3'b010, 3'b100: illegal = 1'b0;
`ifdef LSU_HALFWORD_EN
                3'b001, 3'b101:         illegal = 1'b0;
`endif
                default:                illegal = 1'b1;
            endcase
        end else begin
            case (funct3M)
                3'b000, 3'b010: illegal = 1'b0;
`ifdef LSU_HALFWORD_EN
                3'b001:         illegal = 1'b0;
`endif
                default:        illegal = 1'b1;
            endcase
        end

        misaligned = 1'b0;
        st_wd      = WriteDataM;
        st_be      = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                st_wd = {4{WriteDataM[7:0]}};
                st_be = 4'b0001 << off;
            end
`ifdef LSU_HALFWORD_EN
            2'b01: begin
                misaligned = off[0];
                st_wd      = {2{WriteDataM[15:0]}};
                st_be      = 4'b0011 << off;
            end
`endif
            default: misaligned = (off != 2'b00);
        endcase
    end

    // Select the addressed lane of the returned word and extend it.
    always_comb begin
        lane = dmem_RD >> {off_q, 3'b000};
        case (f3_q)
            3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
            3'b100:  ld_data = {24'h0, lane[7:0]};
`ifdef LSU_HALFWORD_EN
            3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
            3'b101:  ld_data = {16'h0, lane[15:0]};
`endif
            default: ld_data = lane;
        endcase
    end

    // Next state, next register values and the combinational stall.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;
        f3_d      = f3_q;
        off_d     = off_q;
        is_load_d = is_load_q;
        req_d     = dmem_req;
        a_d       = dmem_A;
        wd_d      = dmem_WD;
        be_d      = dmem_BE;
        we_d      = dmem_WE;
        rd_d      = ReadDataM;
        exc_d     = 1'b0;
        cause_d   = ExcCauseM;
        StallM    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    StallM = 1'b1;
                    if (illegal) begin
                        state_d = S_DONE;
                        exc_d   = 1'b1;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (misaligned) begin
                        state_d = S_DONE;
                        exc_d   = 1'b1;
                        cause_d = MemReadM ? CAUSE_LD_MISAL : CAUSE_ST_MISAL;
                    end else begin
                        state_d   = S_BUSY;
                        req_d     = 1'b1;
                        a_d       = {ALUResultM[ADDR_W-1:2], 2'b00};
                        wd_d      = st_wd;
                        be_d      = st_be;
                        we_d      = MemWriteM;
                        f3_d      = funct3M;
                        off_d     = off;
                        is_load_d = MemReadM;
                        cnt_d     = 8'h00;
                        discard_d = 1'b0;
                    end
                end
            end
            S_BUSY: begin
                StallM = 1'b1;
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 8'd1;
                if (FlushM) begin
                    discard_d = 1'b1;
                end
                if (dmem_ready || (cnt_q == TIMEOUT_CNT)) begin
                    req_d     = 1'b0;
                    we_d      = 1'b0;
                    discard_d = 1'b0;
                    if (discard_q || FlushM) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                        if (dmem_ready && !dmem_err) begin
                            if (is_load_q) begin
                                rd_d = ld_data;
                            end
                        end else begin
                            exc_d   = 1'b1;
                            cause_d = is_load_q ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            discard_q <= 1'b0;
            cnt_q     <= 8'h00;
            f3_q      <= 3'b000;
            off_q     <= 2'b00;
            is_load_q <= 1'b0;
            dmem_req  <= 1'b0;
            dmem_A    <= '0;
            dmem_WD   <= 32'h0;
            dmem_BE   <= 4'h0;
            dmem_WE   <= 1'b0;
            ReadDataM <= 32'h0;
            ExcM      <= 1'b0;
            ExcCauseM <= 4'h0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
            f3_q      <= f3_d;
            off_q     <= off_d;
            is_load_q <= is_load_d;
            dmem_req  <= req_d;
            dmem_A    <= a_d;
            dmem_WD   <= wd_d;
            dmem_BE   <= be_d;
            dmem_WE   <= we_d;
            ReadDataM <= rd_d;
            ExcM      <= exc_d;
            ExcCauseM <= cause_d;
        end
    end

endmodule
